// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit saturating-style entry state and its encodings.
package bp_pkg;

    typedef logic [1:0] bp_state_t;

    localparam bp_state_t S_NT = 2'b00;
    localparam bp_state_t W_NT = 2'b01;
    localparam bp_state_t W_T  = 2'b10;
    localparam bp_state_t S_T  = 2'b11;

    localparam bp_state_t INIT_STATE_DEFAULT = W_NT;

    typedef enum logic {
        PHT_INIT = 1'b0,
        PHT_RUN  = 1'b1
    } pht_phase_t;

endpackage

// File: rtl/predictor_next_state.sv
// Combinational training rule for one predictor entry given the resolved outcome.
module predictor_next_state
    import bp_pkg::*;
(
    input  bp_state_t state_in,
    input  logic      taken,
    output bp_state_t state_out
);

    // A taken outcome from strongly-not-taken jumps to weakly-taken, not weakly-not-taken.
    always_comb begin
        state_out = state_in;
        if (taken) begin
            case (state_in)
                S_NT:    state_out = W_T;
                W_NT:    state_out = S_T;
                W_T:     state_out = S_T;
                default: state_out = S_T;
            endcase
        end else begin
            case (state_in)
                S_NT:    state_out = S_NT;
                W_NT:    state_out = S_NT;
                W_T:     state_out = S_NT;
                default: state_out = W_NT;
            endcase
        end
    end

endmodule

// File: rtl/pattern_history_table.sv
// Pattern history table: INIT sweep fills every entry, then RUN services lookups
// (one-cycle latency, write-first against a same-cycle update) and single-cycle training.
//
//   phase    | meaning
//   ---------+------------------------------------------------------------
//   PHT_INIT | writing INIT_STATE to entry init_count_q, one per enabled cycle
//   PHT_RUN  | Ready high; lookups and updates serviced
module pattern_history_table
    import bp_pkg::*;
#(
    parameter int        INDEX_WIDTH = 6,
    parameter bp_state_t INIT_STATE  = INIT_STATE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   clk_en,
    input  logic                   sync_rst,
    output logic                   Ready,
    input  logic                   LookupValid,
    input  logic [INDEX_WIDTH-1:0] LookupIndex,
    output logic                   PredictValid,
    output logic                   PredictTaken,
    output logic [1:0]             PredictState,
    input  logic                   UpdateValid,
    input  logic [INDEX_WIDTH-1:0] UpdateIndex,
    input  logic                   UpdateTaken
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;

    pht_phase_t             phase_q, phase_d;
    logic [INDEX_WIDTH-1:0] init_count_q, init_count_d;
    bp_state_t              table_q [ENTRIES];
    bp_state_t              table_d [ENTRIES];
    logic                   predict_valid_q, predict_valid_d;
    bp_state_t              predict_state_q, predict_state_d;
    bp_state_t              upd_cur;
    bp_state_t              upd_next;
    logic                   run;

    assign run     = (phase_q == PHT_RUN);
    assign upd_cur = table_q[UpdateIndex];

    predictor_next_state u_next_state (
        .state_in  (upd_cur),
        .taken     (UpdateTaken),
        .state_out (upd_next)
    );

    always_comb begin
        phase_d         = phase_q;
        init_count_d    = init_count_q;
        table_d         = table_q;
        predict_valid_d = predict_valid_q;
        predict_state_d = predict_state_q;
        if (clk_en) begin
            predict_valid_d = 1'b0;
            if (!run) begin
                table_d[init_count_q] = INIT_STATE;
                init_count_d          = init_count_q + 1'b1;
                if (init_count_q == '1) begin
                    phase_d = PHT_RUN;
                end
            end else begin
                if (UpdateValid) begin
                    table_d[UpdateIndex] = upd_next;
                end
                // Reading the post-write array makes a same-index lookup see the update.
                if (LookupValid) begin
                    predict_valid_d = 1'b1;
                    predict_state_d = table_d[LookupIndex];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            phase_q         <= PHT_INIT;
            init_count_q    <= '0;
            predict_valid_q <= 1'b0;
            predict_state_q <= S_NT;
        end else begin
            phase_q         <= phase_d;
            init_count_q    <= init_count_d;
            predict_valid_q <= predict_valid_d;
            predict_state_q <= predict_state_d;
        end
    end

    // Contents are defined by the INIT sweep, so the array itself has no reset.
    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

    assign Ready        = run;
    assign PredictValid = predict_valid_q;
    assign PredictState = predict_state_q;
    assign PredictTaken = predict_state_q[1];

endmodule

// File: tb/tb_pattern_history_table.sv
// Self-checking bench: per-cycle compare against a behavioural table model plus directed literal checks.
module tb_pattern_history_table;
    import bp_pkg::*;

    localparam int IW = 6;
    localparam int N  = 64;

    logic          clk = 1'b0;
    logic          clk_en = 1'b1;
    logic          sync_rst = 1'b1;
    logic          LookupValid = 1'b0;
    logic [IW-1:0] LookupIndex = '0;
    logic          UpdateValid = 1'b0;
    logic [IW-1:0] UpdateIndex = '0;
    logic          UpdateTaken = 1'b0;
    logic          Ready;
    logic          PredictValid;
    logic          PredictTaken;
    logic [1:0]    PredictState;

    always #5 clk = ~clk;

    pattern_history_table #(.INDEX_WIDTH(IW), .INIT_STATE(2'b01)) dut (
        .clk          (clk),
        .clk_en       (clk_en),
        .sync_rst     (sync_rst),
        .Ready        (Ready),
        .LookupValid  (LookupValid),
        .LookupIndex  (LookupIndex),
        .PredictValid (PredictValid),
        .PredictTaken (PredictTaken),
        .PredictState (PredictState),
        .UpdateValid  (UpdateValid),
        .UpdateIndex  (UpdateIndex),
        .UpdateTaken  (UpdateTaken)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: entries as integers, readiness as a count of enabled cycles since reset.
    int m_tbl [N];
    int m_done = 0;
    bit m_known = 1'b0;
    int m_pv = 0;
    int m_ps = 0;

    function automatic int train(input int s, input bit t);
        if (t) return (s == 0) ? 2 : 3;
        return (s == 3) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        if (sync_rst) begin
            m_known = 1'b1;
            m_done  = 0;
            m_pv    = 0;
            m_ps    = 0;
        end else if (clk_en && m_known) begin
            if (m_done < N) begin
                m_tbl[m_done] = 1;
                m_done++;
                m_pv = 0;
            end else begin
                if (UpdateValid) m_tbl[UpdateIndex] = train(m_tbl[UpdateIndex], UpdateTaken);
                m_pv = LookupValid ? 1 : 0;
                if (LookupValid) m_ps = m_tbl[LookupIndex];
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("model_ready", int'(Ready), (m_done >= N) ? 1 : 0);
            check("model_pvalid", int'(PredictValid), m_pv);
            check("model_pstate", int'(PredictState), m_ps);
            check("model_ptaken", int'(PredictTaken), m_ps / 2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        LookupValid = 1'b0;
        UpdateValid = 1'b0;
        UpdateTaken = 1'b0;
    endtask

    task automatic upd(input int idx, input bit t);
        UpdateValid = 1'b1;
        UpdateIndex = IW'(idx);
        UpdateTaken = t;
        LookupValid = 1'b0;
        cyc();
        idle();
    endtask

    task automatic lk_check(input string name, input int idx, input int exp);
        LookupValid = 1'b1;
        LookupIndex = IW'(idx);
        UpdateValid = 1'b0;
        cyc();
        idle();
        check({name, "_pv"}, int'(PredictValid), 1);
        check({name, "_ps"}, int'(PredictState), exp);
        check({name, "_pt"}, int'(PredictTaken), exp / 2);
    endtask

    initial begin
        bit train_t [8];
        int train_e [8];
        train_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        train_e = '{3, 3, 3, 3, 1, 0, 2, 0};

        // reset values
        cyc();
        cyc();
        check("rst_ready", int'(Ready), 0);
        check("rst_pv", int'(PredictValid), 0);
        check("rst_ps", int'(PredictState), 0);
        check("rst_pt", int'(PredictTaken), 0);

        // first sweep, with a lookup+update attempt at cycle 10
        sync_rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == 10) begin
                LookupValid = 1'b1; LookupIndex = 6'd20;
                UpdateValid = 1'b1; UpdateIndex = 6'd20; UpdateTaken = 1'b1;
            end else begin
                idle();
            end
            cyc();
            if (i == 10) check("init_lookup_pv", int'(PredictValid), 0);
            if (i == N - 2) check("sweep_ready_63", int'(Ready), 0);
            if (i == N - 1) check("sweep_ready_64", int'(Ready), 1);
        end
        idle();

        for (int i = 0; i < N; i++) lk_check("init_all", i, 1);
        lk_check("init_dropped_upd", 20, 1);

        // training sequence on index 5
        for (int k = 0; k < 8; k++) begin
            upd(5, train_t[k]);
            lk_check("train5", 5, train_e[k]);
        end

        // same-cycle lookup and update, same index (write-first)
        LookupValid = 1'b1; LookupIndex = 6'd9;
        UpdateValid = 1'b1; UpdateIndex = 6'd9; UpdateTaken = 1'b1;
        cyc();
        idle();
        check("wf9_pv", int'(PredictValid), 1);
        check("wf9_ps", int'(PredictState), 3);
        check("wf9_pt", int'(PredictTaken), 1);

        // same-cycle lookup and update, different indices
        LookupValid = 1'b1; LookupIndex = 6'd9;
        UpdateValid = 1'b1; UpdateIndex = 6'd10; UpdateTaken = 1'b1;
        cyc();
        idle();
        check("indep_ps", int'(PredictState), 3);
        lk_check("indep10", 10, 3);

        // clk_en low in RUN holds outputs and ignores strobes
        lk_check("hold_pre", 5, 0);
        clk_en = 1'b0;
        LookupValid = 1'b1; LookupIndex = 6'd9;
        UpdateValid = 1'b1; UpdateIndex = 6'd5; UpdateTaken = 1'b1;
        repeat (3) cyc();
        check("hold_pv", int'(PredictValid), 1);
        check("hold_ps", int'(PredictState), 0);
        idle();
        clk_en = 1'b1;
        lk_check("hold_post5", 5, 0);

        // sweep with 8 disabled cycles and strobes inside the window
        sync_rst = 1'b1;
        cyc();
        sync_rst = 1'b0;
        for (int i = 0; i < N + 8; i++) begin
            clk_en = !(i >= 20 && i < 28);
            if (!clk_en) begin
                LookupValid = 1'b1; LookupIndex = 6'd11;
                UpdateValid = 1'b1; UpdateIndex = 6'd11; UpdateTaken = 1'b1;
            end else begin
                idle();
            end
            cyc();
            if (!clk_en) check("gap_pv", int'(PredictValid), 0);
            if (i == N + 6) check("gap_ready_71", int'(Ready), 0);
            if (i == N + 7) check("gap_ready_72", int'(Ready), 1);
        end
        clk_en = 1'b1;
        idle();
        lk_check("gap_idx11", 11, 1);

        // reset in RUN reruns the sweep
        upd(3, 1'b1);
        lk_check("pre_rst3", 3, 3);
        sync_rst = 1'b1;
        cyc();
        check("rerun_ready_rst", int'(Ready), 0);
        sync_rst = 1'b0;
        repeat (N - 1) cyc();
        check("rerun_ready_63", int'(Ready), 0);
        cyc();
        check("rerun_ready_64", int'(Ready), 1);
        lk_check("rerun_idx3", 3, 1);

        // randomized traffic; the per-cycle compare process checks every cycle
        for (int c = 0; c < 4000; c++) begin
            clk_en      = ($urandom % 10) != 0;
            sync_rst    = ($urandom % 400) == 0;
            LookupValid = $urandom % 2;
            UpdateValid = $urandom % 2;
            UpdateTaken = $urandom % 2;
            LookupIndex = (($urandom % 3) == 0) ? IW'($urandom % 4) : IW'($urandom % N);
            UpdateIndex = (($urandom % 3) == 0) ? IW'($urandom % 4) : IW'($urandom % N);
            cyc();
        end
        idle();
        sync_rst = 1'b0;
        clk_en = 1'b1;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
